// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants for the multi-word add/subtract sequencer.
// State encodings are plain constants so older tools and waveform scripts can match them.
package wide_add_sequencer_pkg;

   localparam int WORD_W = 64;

   typedef logic [WORD_W-1:0] word_t;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/adder_64bit.sv
// Purely combinational 64-bit adder with carry in and carry out.
// The sequencer reuses this single instance once per operand word.
module adder_64bit
   import wide_add_sequencer_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built from one 64-bit adder, one word per cycle, LSW first.
// Operands are captured on acceptance so the producer may change them during the run.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter  int WORDS = 4,
   localparam int IDXW  = $clog2(WORDS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    op_sub,
   input  logic [WORDS*WORD_W-1:0] a,
   input  logic [WORDS*WORD_W-1:0] b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORDS*WORD_W-1:0] sum,
   output logic                    cout
);

   logic [1:0]              state;
   logic [IDXW-1:0]         idx;
   logic                    carry;
   logic                    sub_reg;
   logic [WORDS*WORD_W-1:0] a_reg;
   logic [WORDS*WORD_W-1:0] b_reg;
   word_t                   add_a;
   word_t                   add_b;
   word_t                   add_sum;
   logic                    add_cout;
   logic                    last_word;

   assign in_ready  = (state == IDLE);
   assign last_word = (idx == IDXW'(WORDS - 1));

   // Subtraction feeds the inverted B word; the +1 comes from the carry seeded at acceptance.
   always_comb begin
      add_a = a_reg[WORD_W*int'(idx) +: WORD_W];
      add_b = b_reg[WORD_W*int'(idx) +: WORD_W];
      if (sub_reg) begin
         add_b = ~add_b;
      end
   end

   adder_64bit u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         sub_reg   <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg   <= a;
                  b_reg   <= b;
                  sub_reg <= op_sub;
                  idx     <= '0;
                  carry   <= op_sub;
                  state   <= RUN;
               end
            end
            RUN: begin
               sum[WORD_W*int'(idx) +: WORD_W] <= add_sum;
               carry                           <= add_cout;
               if (last_word) begin
                  cout      <= add_cout;
                  out_valid <= 1'b1;
                  idx       <= '0;
                  state     <= DONE;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed corner cases plus random
// operations compared against a whole-number arithmetic model.
module tb_wide_add_sequencer;

   localparam int WORDS = 4;
   localparam int W     = WORDS * 64;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   int           total;
   int           bad;
   int           cyc;
   int           acceptCyc;
   logic [W-1:0] expSum;
   logic         expCout;

   wide_add_sequencer #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] randWide();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) begin
         r[32*i +: 32] = $urandom;
      end
      return r;
   endfunction

   // Reference: plain unsigned arithmetic on the full-width operands.
   task automatic modelOp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
      logic [W:0] wide;
      if (sv) begin
         expSum  = av - bv;
         expCout = (av >= bv);
      end else begin
         wide    = {1'b0, av} + {1'b0, bv};
         expSum  = wide[W-1:0];
         expCout = wide[W];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input bit busy);
      int waited;
      @(negedge clk);
      a        = av;
      b        = bv;
      op_sub   = sv;
      in_valid = 1'b1;
      waited   = 0;
      while (in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("accept_ready", W'(in_ready), W'(1));
      @(posedge clk);
      #1;
      acceptCyc = cyc;
      modelOp(av, bv, sv);
      if (busy) begin
         a      = randWide();
         b      = randWide();
         op_sub = ~sv;
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic collectResult(input int holdCycles);
      int waited;
      waited = 0;
      @(negedge clk);
      checkOutput("run_in_ready", W'(in_ready), W'(0));
      while (out_valid !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("out_valid_seen", W'(out_valid), W'(1));
      checkOutput("latency", W'(cyc - acceptCyc), W'(WORDS));
      checkOutput("sum", sum, expSum);
      checkOutput("cout", W'(cout), W'(expCout));
      for (int h = 0; h < holdCycles; h++) begin
         @(negedge clk);
         checkOutput("hold_valid", W'(out_valid), W'(1));
         checkOutput("hold_sum", sum, expSum);
         checkOutput("hold_cout", W'(cout), W'(expCout));
         checkOutput("hold_in_ready", W'(in_ready), W'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("post_hs_valid", W'(out_valid), W'(0));
      checkOutput("post_hs_ready", W'(in_ready), W'(1));
   endtask

   initial begin
      logic [W-1:0] allOnes;
      logic [W-1:0] op2a;
      logic [W-1:0] op2b;
      int           waited;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_sub    = 1'b0;
      a         = '0;
      b         = '0;
      allOnes   = '1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_valid", W'(out_valid), W'(0));
      checkOutput("rst_sum", sum, '0);
      checkOutput("rst_cout", W'(cout), W'(0));
      checkOutput("rst_in_ready", W'(in_ready), W'(1));
      rst_n = 1'b1;

      $display("[TB] directed corner cases");
      applyStimulus(W'(123), W'(123), 1'b0, 1'b0);
      collectResult(0);
      applyStimulus(allOnes, W'(1), 1'b0, 1'b0);
      collectResult(0);
      applyStimulus(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b0);
      collectResult(0);
      applyStimulus(W'(5), W'(7), 1'b1, 1'b0);
      collectResult(0);
      applyStimulus(W'(7), W'(5), 1'b1, 1'b0);
      collectResult(0);
      op2a = randWide();
      applyStimulus(op2a, op2a, 1'b1, 1'b0);
      collectResult(0);

      $display("[TB] backpressure with ignored input traffic");
      applyStimulus(randWide(), randWide(), 1'b0, 1'b1);
      collectResult(3);
      applyStimulus(randWide(), randWide(), 1'b1, 1'b1);
      collectResult(3);

      $display("[TB] random operations");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(randWide(), randWide(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         collectResult(int'($urandom_range(0, 2)));
      end

      $display("[TB] reset during RUN");
      applyStimulus(randWide(), randWide(), 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_valid", W'(out_valid), W'(0));
      checkOutput("midrst_sum", sum, '0);
      checkOutput("midrst_cout", W'(cout), W'(0));
      checkOutput("midrst_in_ready", W'(in_ready), W'(1));
      rst_n = 1'b1;
      applyStimulus(W'(1), W'(1), 1'b0, 1'b0);
      collectResult(0);

      $display("[TB] back-to-back with out_ready high");
      out_ready = 1'b1;
      op2a      = randWide();
      op2b      = randWide();
      applyStimulus(randWide(), randWide(), 1'b0, 1'b0);
      a        = op2a;
      b        = op2b;
      op_sub   = 1'b1;
      in_valid = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("b2b_first_valid", W'(out_valid), W'(1));
      checkOutput("b2b_first_latency", W'(cyc - acceptCyc), W'(WORDS));
      checkOutput("b2b_first_sum", sum, expSum);
      checkOutput("b2b_first_cout", W'(cout), W'(expCout));
      @(negedge clk);
      checkOutput("b2b_gap_ready", W'(in_ready), W'(1));
      checkOutput("b2b_gap_valid", W'(out_valid), W'(0));
      @(posedge clk);
      #1;
      acceptCyc = cyc;
      in_valid  = 1'b0;
      modelOp(op2a, op2b, 1'b1);
      collectResult(0);
      out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
